// File: rtl/gate_truth_checker.sv
// Sweeps all 32 input combinations into the buffer/XNOR/NAND gate unit and
// checks each response. The build macro CHECK_FIRST_FAIL_EN adds first-fail capture.
module gate_truth_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       x1,
   output logic       x2,
   output logic       y2,
   output logic       x3,
   output logic       y3,
   input  logic       z1,
   input  logic       z2,
   input  logic       z3,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] err_count,
   output logic [2:0] err_flags,
   output logic [1:0] fsm_state
`ifdef CHECK_FIRST_FAIL_EN
   ,
   output logic       first_fail_valid,
   output logic [4:0] first_fail_vec,
   output logic [2:0] first_fail_z
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [4:0] vec;
   logic [3:0] cnt;
   logic [4:0] stim;
   logic       sample;
   logic       last_vec;
   logic       start_sweep;
   logic       e1, e2, e3;
   logic [2:0] mismatch;
   logic [5:0] count_next;

   // Expected values come from the stimulus actually on the wires, not from vec.
   assign e1 = stim[4];
   assign e2 = ~(stim[3] ^ stim[2]);
   assign e3 = ~(stim[1] & stim[0]);

   // Case inequality so an X or Z response is flagged rather than hidden.
   assign mismatch = {z3 !== e3, z2 !== e2, z1 !== e1};

   assign sample      = (state == RUN) && (cnt == CNT_LAST);
   assign last_vec    = (vec == 5'd31);
   assign start_sweep = (state != RUN) && start;
   assign count_next  = ((|mismatch) && (err_count < 6'd32)) ? err_count + 6'd1 : err_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (sample && last_vec) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec       <= '0;
         cnt       <= '0;
         stim      <= '0;
         err_count <= '0;
         err_flags <= '0;
         pass      <= 1'b0;
      end else if (start_sweep) begin
         vec       <= '0;
         cnt       <= '0;
         stim      <= '0;
         err_count <= '0;
         err_flags <= '0;
         pass      <= 1'b0;
      end else if (sample) begin
         err_flags <= err_flags | mismatch;
         err_count <= count_next;
         cnt       <= '0;
         if (last_vec) begin
            stim <= '0;
            pass <= (count_next == 6'd0);
         end else begin
            vec  <= vec + 5'd1;
            stim <= vec + 5'd1;
         end
      end else if (state == RUN) begin
         cnt <= cnt + 4'd1;
      end
   end

`ifdef CHECK_FIRST_FAIL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
         first_fail_z     <= '0;
      end else if (start_sweep) begin
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
         first_fail_z     <= '0;
      end else if (sample && (|mismatch) && !first_fail_valid) begin
         first_fail_valid <= 1'b1;
         first_fail_vec   <= stim;
         first_fail_z     <= {z3, z2, z1};
      end
   end
`endif

   assign {x1, x2, y2, x3, y3} = stim;
   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign fsm_state = state;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: golden and faulty gate models, restart,
// mid-sweep reset and a SETTLE_CYCLES=1 instance. Honours CHECK_FIRST_FAIL_EN.
module tb_gate_truth_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start1 = 1'b0;
   logic [1:0] mode = 2'd0;   // 0 golden, 1 z3 stuck at 1, 2 z2 inverted

   logic x1, x2, y2, x3, y3, z1, z2, z3;
   logic busy, done, pass;
   logic [5:0] err_count;
   logic [2:0] err_flags;
   logic [1:0] fsm_state;

   logic a1, a2, b2, a3, b3, w1, w2, w3;
   logic busy1, done1, pass1;
   logic [5:0] err_count1;
   logic [2:0] err_flags1;
   logic [1:0] fsm_state1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign z1 = x1;
   assign z2 = (mode == 2'd2) ? (x2 ^ y2) : ~(x2 ^ y2);
   assign z3 = (mode == 2'd1) ? 1'b1 : ~(x3 & y3);

   assign w1 = a1;
   assign w2 = ~(a2 ^ b2);
   assign w3 = ~(a3 & b3);

`ifdef CHECK_FIRST_FAIL_EN
   logic       ff_valid, ff_valid1;
   logic [4:0] ff_vec, ff_vec1;
   logic [2:0] ff_z, ff_z1;
`endif

   gate_truth_checker #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .x1(x1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
      .z1(z1), .z2(z2), .z3(z3),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .err_flags(err_flags), .fsm_state(fsm_state)
`ifdef CHECK_FIRST_FAIL_EN
      , .first_fail_valid(ff_valid), .first_fail_vec(ff_vec), .first_fail_z(ff_z)
`endif
   );

   gate_truth_checker #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .x1(a1), .x2(a2), .y2(b2), .x3(a3), .y3(b3),
      .z1(w1), .z2(w2), .z3(w3),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err_count1), .err_flags(err_flags1), .fsm_state(fsm_state1)
`ifdef CHECK_FIRST_FAIL_EN
      , .first_fail_valid(ff_valid1), .first_fail_vec(ff_vec1), .first_fail_z(ff_z1)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] stim_of(input int which);
      return (which != 0) ? {a1, a2, b2, a3, b3} : {x1, x2, y2, x3, y3};
   endfunction

   function automatic logic busy_of(input int which);
      return (which != 0) ? busy1 : busy;
   endfunction

   function automatic logic done_of(input int which);
      return (which != 0) ? done1 : done;
   endfunction

   function automatic logic [5:0] count_of(input int which);
      return (which != 0) ? err_count1 : err_count;
   endfunction

   // Pulses start, checks the stimulus after every edge and measures start-to-done
   // latency. restart_at < 0 disables the extra start pulse issued mid-sweep.
   task automatic run_sweep(input int which, input int settle, input int restart_at);
      int n;
      int cycles;
      @(negedge clk);
      if (which != 0) start1 = 1'b1; else start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      start1 = 1'b0;
      check("start_busy", 32'(busy_of(which)), 32'd1);
      check("start_done", 32'(done_of(which)), 32'd0);
      check("start_vec0", 32'(stim_of(which)), 32'd0);
      check("start_cnt_clr", 32'(count_of(which)), 32'd0);
`ifdef CHECK_FIRST_FAIL_EN
      if (which == 0) check("start_ff_clr", {ff_valid, ff_vec, ff_z}, 32'd0);
`endif
      n = 0;
      cycles = -1;
      while (n < 200 && cycles < 0) begin
         if (n == restart_at) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
         if (done_of(which)) cycles = n;
         else check("stim", 32'(stim_of(which)), 32'(n / settle));
      end
      check("sweep_cycles", cycles, 32 * settle);
      check("end_busy", 32'(busy_of(which)), 32'd0);
      check("end_stim", 32'(stim_of(which)), 32'd0);
   endtask

   initial begin
      // Reset values
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_count", 32'(err_count), 32'd0);
      check("rst_flags", 32'(err_flags), 32'd0);
      check("rst_stim", 32'({x1, x2, y2, x3, y3}), 32'd0);
      check("rst_state", 32'(fsm_state), 32'd0);
`ifdef CHECK_FIRST_FAIL_EN
      check("rst_ff", {ff_valid, ff_vec, ff_z}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Golden unit
      mode = 2'd0;
      run_sweep(0, 2, -1);
      check("gold_count", 32'(err_count), 32'd0);
      check("gold_flags", 32'(err_flags), 32'd0);
      check("gold_pass", 32'(pass), 32'd1);
`ifdef CHECK_FIRST_FAIL_EN
      check("gold_ff", {ff_valid, ff_vec, ff_z}, 32'd0);
`endif

      // z3 stuck at 1: fails only where x3=y3=1 (8 vectors)
      mode = 2'd1;
      run_sweep(0, 2, -1);
      check("z3s_count", 32'(err_count), 32'd8);
      check("z3s_flags", 32'(err_flags), 32'b100);
      check("z3s_pass", 32'(pass), 32'd0);
`ifdef CHECK_FIRST_FAIL_EN
      // vec 3 drives x1=0, x2=y2=0, so the captured response is {1,1,0}
      check("z3s_ff_valid", 32'(ff_valid), 32'd1);
      check("z3s_ff_vec", 32'(ff_vec), 32'd3);
      check("z3s_ff_z", 32'(ff_z), 32'b110);
`endif

      // z2 inverted: every vector fails
      mode = 2'd2;
      run_sweep(0, 2, -1);
      check("z2i_count", 32'(err_count), 32'd32);
      check("z2i_flags", 32'(err_flags), 32'b010);
      check("z2i_pass", 32'(pass), 32'd0);
`ifdef CHECK_FIRST_FAIL_EN
      check("z2i_ff_valid", 32'(ff_valid), 32'd1);
      check("z2i_ff_vec", 32'(ff_vec), 32'd0);
      check("z2i_ff_z", 32'(ff_z), 32'b100);
`endif

      // Start from DONE reruns; a second start at cycle 10 is ignored
      check("done_held", 32'(done), 32'd1);
      mode = 2'd0;
      run_sweep(0, 2, 10);
      check("rerun_count", 32'(err_count), 32'd0);
      check("rerun_flags", 32'(err_flags), 32'd0);
      check("rerun_pass", 32'(pass), 32'd1);

      // Asynchronous reset mid-sweep
      mode = 2'd1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_stim", 32'({x1, x2, y2, x3, y3}), 32'd0);
      check("mid_rst_count", 32'(err_count), 32'd0);
      check("mid_rst_flags", 32'(err_flags), 32'd0);
      check("mid_rst_state", 32'(fsm_state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mode = 2'd0;
      run_sweep(0, 2, -1);
      check("post_rst_count", 32'(err_count), 32'd0);
      check("post_rst_pass", 32'(pass), 32'd1);

      // SETTLE_CYCLES=1 instance with golden unit
      run_sweep(1, 1, -1);
      check("s1_count", 32'(err_count1), 32'd0);
      check("s1_flags", 32'(err_flags1), 32'd0);
      check("s1_pass", 32'(pass1), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
